muldiv_hilo_ctrl: RTL and testbench
===================================

// Module: muldiv_hilo_ctrl
// PURPOSE
//  Sequences the iterative Mult and Div units for the execute stage and owns the architectural HI/LO pair.
//  Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from funct, pulses the selected unit, and stalls the pipeline until the result returns.
//  Commits results to HI/LO and serves MFHI/MFLO reads. Sits beside the single-cycle ALU; the ALU never writes HI/LO itself.
// PARAMETERS
//  WIDTH    32  datapath width of SrcA/SrcB/HI/LO
//  TIMEOUT  64  max cycles in BUSY before abort (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous active-low reset
//  op_valid   in   1      execute stage holds a valid R-type op; held stable while stall=1
//  funct      in   6      R-type funct field
//  flush      in   1      pipeline flush; aborts any in-flight op
//  SrcA       in   WIDTH  rs operand
//  SrcB       in   WIDTH  rt operand
//  mul_validIn  out 1     one-cycle start pulse to Mult
//  mul_sign     out 1     1=MULT, 0=MULTU; held from start until done
//  mul_validOut in  1     Mult result valid
//  mul_hi/mul_lo in WIDTH Mult result
//  div_validIn  out 1     one-cycle start pulse to Div
//  div_sign     out 1     1=DIV, 0=DIVU; held from start until done
//  div_validOut in  1     Div result valid (hi=remainder, lo=quotient)
//  div_hi/div_lo in WIDTH Div result
//  stall      out  1      freeze fetch/decode/execute
//  mf_data    out  WIDTH  HI (MFHI) or LO (MFLO), else 0
//  Hi, Lo     out  WIDTH  architectural HI/LO
//  timeout_err out 1      one-cycle pulse on unit timeout
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE; Hi=Lo=0; all valid/start/sign outs=0; timeout_err=0; cycle counter=0.
//  Decode: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011, MFHI 010000, MFLO 010010.
//  FSM states IDLE, MBUSY, DBUSY, DONE.
//   IDLE: op_valid & MULT/U -> mul_validIn=1 this cycle, latch sign, ->MBUSY. DIV/U with SrcB!=0 -> div_validIn=1, ->DBUSY.
//   DIV/U with SrcB==0: no start, HI/LO unchanged, no stall, stay IDLE.
//   MTHI/MTLO in IDLE: Hi<=SrcA / Lo<=SrcA at next edge, no stall.
//   MBUSY/DBUSY: wait on the matching validOut; on it, Hi/Lo<=unit hi/lo at that edge, ->DONE. Other unit's validOut ignored.
//   DONE: stall=0 for exactly one cycle so the op retires; ->IDLE. No new start is accepted in DONE.
//  stall (combinational) = (IDLE & op_valid & mul/div start condition) | MBUSY | DBUSY; 0 in DONE.
//  Minimum stall = 1 (issue cycle) + unit latency cycles.
//  Timeout: counter clears on entry to BUSY, increments each BUSY cycle; at TIMEOUT-1 with no validOut -> IDLE, timeout_err pulse, HI/LO unchanged.
//  flush (any state): ->IDLE next edge, no HI/LO write, validOut arriving that cycle discarded. flush has priority over validOut; reset has priority over all.
//  mf_data is combinational from the current Hi/Lo regs; MTHI followed by MFHI next cycle reads the new value.
//  No bypass on the same cycle: MFHI in the cycle Hi is written returns the old value.
//  funct not in the list: no action, no stall. An op_valid drop during BUSY without flush does not abort.
//  Start pulses are never high for two consecutive cycles.
// TESTING
//  MULT SrcA=-3 SrcB=5, Mult done after 4 cycles -> mul_validIn pulses once, mul_sign=1, stall 5 cycles, Hi=FFFFFFFF, Lo=FFFFFFF1.
//  DIVU 100/7 -> div_sign=0, then Hi=2, Lo=14, 1 DONE cycle stall=0; MFLO next -> mf_data=14.
//  DIV SrcB=0 with Hi=0xAA -> no div_validIn, stall=0, Hi stays 0xAA.
//  MTHI 0x1234 then MFHI -> Hi=0x1234 after 1 edge, mf_data=0x1234 with no stall.
//  MULTU with unit never responding, TIMEOUT=8 -> stall ends after 8 cycles, timeout_err 1 pulse, Hi/Lo unchanged.
//  flush in 2nd BUSY cycle, and reset_n=0 mid-DBUSY -> IDLE next edge, no HI/LO write; reset also zeroes Hi/Lo.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// Purpose : sequences the iterative Mult/Div units and owns the architectural HI/LO pair.
// Latency : MT*/MF* and DIV-by-zero take no extra cycles; MULT*/DIV* stall for 1 + unit latency, then one DONE cycle.
// Backpres: stall freezes the front end while a unit is busy; flush and timeout abort without a HI/LO write.
//
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset
//   op_valid, funct, SrcA, SrcB  execute-stage R-type op and its operands
//   flush                        abort any in-flight op and return to IDLE
//   mul_validIn/mul_sign         start pulse and signedness for the Mult unit
//   mul_validOut/mul_hi/mul_lo   Mult unit result
//   div_validIn/div_sign         start pulse and signedness for the Div unit
//   div_validOut/div_hi/div_lo   Div unit result (hi=remainder, lo=quotient)
//   stall                        freeze fetch/decode/execute
//   mf_data                      HI for MFHI, LO for MFLO, else 0
//   Hi, Lo                       architectural HI/LO
//   timeout_err                  one-cycle pulse when a unit fails to answer in time
module muldiv_hilo_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic             flush,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             mul_validIn,
    output logic             mul_sign,
    input  logic             mul_validOut,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    output logic             div_validIn,
    output logic             div_sign,
    input  logic             div_validOut,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             timeout_err
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MBUSY = 2'd1,
        S_DBUSY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             mul_sign_q, mul_sign_d;
    logic             div_sign_q, div_sign_d;

    logic is_mul;
    logic is_div;
    logic divisor_zero;
    logic mul_start;
    logic div_start;
    logic timeout_hit;

    // Decode is independent of state; starts are only honoured in IDLE.
    always_comb begin
        is_mul       = (funct == F_MULT) || (funct == F_MULTU);
        is_div       = (funct == F_DIV)  || (funct == F_DIVU);
        divisor_zero = (SrcB == '0);
        // A flushed op must not start a unit whose result we would then drop.
        mul_start    = (state_q == S_IDLE) && op_valid && !flush && is_mul;
        div_start    = (state_q == S_IDLE) && op_valid && !flush && is_div && !divisor_zero;
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        mul_sign_d  = mul_sign_q;
        div_sign_d  = div_sign_q;
        timeout_hit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    state_d    = S_MBUSY;
                    cnt_d      = '0;
                    mul_sign_d = (funct == F_MULT);
                end else if (div_start) begin
                    state_d    = S_DBUSY;
                    cnt_d      = '0;
                    div_sign_d = (funct == F_DIV);
                end else if (op_valid && !flush && (funct == F_MTHI)) begin
                    hi_d = SrcA;
                end else if (op_valid && !flush && (funct == F_MTLO)) begin
                    lo_d = SrcA;
                end
            end

            S_MBUSY: begin
                // flush beats a result arriving in the same cycle.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mul_validOut) begin
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DBUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (div_validOut) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                // The retiring op is still on op_valid here; never restart it.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        mul_validIn = mul_start;
        div_validIn = div_start;
        // Sign is driven straight from funct alongside the start pulse, then held.
        mul_sign    = mul_start ? (funct == F_MULT) : mul_sign_q;
        div_sign    = div_start ? (funct == F_DIV)  : div_sign_q;
        stall       = mul_start || div_start ||
                      (state_q == S_MBUSY) || (state_q == S_DBUSY);
        // Pulses in the last BUSY cycle so the pipeline sees it alongside the abort edge.
        timeout_err = timeout_hit;
        Hi          = hi_q;
        Lo          = lo_q;
        mf_data     = '0;
        if (op_valid && (funct == F_MFHI)) begin
            mf_data = hi_q;
        end else if (op_valid && (funct == F_MFLO)) begin
            mf_data = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            mul_sign_q <= 1'b0;
            div_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            mul_sign_q <= mul_sign_d;
            div_sign_q <= div_sign_d;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;

    localparam int W  = 32;
    localparam int TO = 8;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_valid = 1'b0;
    logic [5:0]   funct = '0;
    logic         flush = 1'b0;
    logic [W-1:0] SrcA = '0, SrcB = '0;
    logic         mul_validIn, mul_sign, div_validIn, div_sign;
    logic         mul_validOut = 1'b0, div_validOut = 1'b0;
    logic [W-1:0] mul_hi = '0, mul_lo = '0, div_hi = '0, div_lo = '0;
    logic         stall, timeout_err;
    logic [W-1:0] mf_data, Hi, Lo;

    int total = 0;
    int bad   = 0;

    // Reference architectural state.
    logic [W-1:0] m_hi = '0, m_lo = '0;

    muldiv_hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .funct(funct), .flush(flush),
        .SrcA(SrcA), .SrcB(SrcB),
        .mul_validIn(mul_validIn), .mul_sign(mul_sign), .mul_validOut(mul_validOut),
        .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_validIn(div_validIn), .div_sign(div_sign), .div_validOut(div_validOut),
        .div_hi(div_hi), .div_lo(div_lo),
        .stall(stall), .mf_data(mf_data), .Hi(Hi), .Lo(Lo), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Arithmetic result a correct unit would produce: {hi, lo}.
    function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        sa = $signed(a);
        sb = $signed(b);
        qa = $signed(a);
        qb = $signed(b);
        case (f)
            F_MULT:  return sa * sb;
            F_MULTU: return {32'd0, a} * {32'd0, b};
            F_DIV:   return {32'(qa % qb), 32'(qa / qb)};
            F_DIVU:  return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // Present one op until it retires; emulate the unit (0=mul, 1=div, 2=silent)
    // answering 'lat' cycles after its start pulse. 'spur' pulses the other
    // unit's validOut one cycle after the start. Called just after a posedge.
    task automatic exec_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input int unit, input bit spur,
                           output int n_stall, output int n_mst, output int n_dst, output int n_tmo,
                           output logic sgn, output int sgn_bad, output logic [W-1:0] mf0);
        int cyc, started;
        bit ended;
        logic [63:0] r;
        r = ref_res(f, a, b);
        n_stall = 0; n_mst = 0; n_dst = 0; n_tmo = 0; sgn = 1'b0; sgn_bad = 0; mf0 = '0;
        cyc = 0; started = -1; ended = 0;
        op_valid = 1'b1; funct = f; SrcA = a; SrcB = b;
        while (!ended) begin
            @(negedge clk);
            if (cyc == 0) mf0 = mf_data;
            if (stall) n_stall++;
            if (timeout_err) n_tmo++;
            if (started >= 0 && stall && ((n_mst > 0 ? mul_sign : div_sign) !== sgn)) sgn_bad++;
            if (mul_validIn) begin n_mst++; started = cyc; sgn = mul_sign; end
            if (div_validIn) begin n_dst++; started = cyc; sgn = div_sign; end
            ended = !stall || timeout_err || (cyc >= 200);
            @(posedge clk); #1;
            mul_validOut = 1'b0; div_validOut = 1'b0;
            mul_hi = $urandom; mul_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
            if (ended) op_valid = 1'b0;
            cyc++;
            if (!ended && started >= 0) begin
                if (cyc == started + lat && unit == 0) begin
                    mul_validOut = 1'b1; mul_hi = r[63:32]; mul_lo = r[31:0];
                end
                if (cyc == started + lat && unit == 1) begin
                    div_validOut = 1'b1; div_hi = r[63:32]; div_lo = r[31:0];
                end
                if (spur && cyc == started + 1) begin
                    if (unit == 0) div_validOut = 1'b1;
                    else           mul_validOut = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        total++; if (stall !== 1'b0)       begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (Hi !== '0)            begin bad++; $display("FAIL reset_hi: got %h want 0", Hi); end
        total++; if (Lo !== '0)            begin bad++; $display("FAIL reset_lo: got %h want 0", Lo); end
        total++; if (mul_validIn !== 1'b0) begin bad++; $display("FAIL reset_mul_vin: got %b want 0", mul_validIn); end
        total++; if (div_validIn !== 1'b0) begin bad++; $display("FAIL reset_div_vin: got %b want 0", div_validIn); end
        total++; if (mul_sign !== 1'b0)    begin bad++; $display("FAIL reset_mul_sign: got %b want 0", mul_sign); end
        total++; if (div_sign !== 1'b0)    begin bad++; $display("FAIL reset_div_sign: got %b want 0", div_sign); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        total++; if (mf_data !== '0)       begin bad++; $display("FAIL reset_mf: got %h want 0", mf_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int ns, nm, nd, nt, sb; logic s; logic [W-1:0] mf;
        exec_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 4, 0, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if (nm !== 1)            begin bad++; $display("FAIL mult_pulses: got %0d want 1", nm); end
        total++; if (nd !== 0)            begin bad++; $display("FAIL mult_div_pulses: got %0d want 0", nd); end
        total++; if (s !== 1'b1)          begin bad++; $display("FAIL mult_sign: got %b want 1", s); end
        total++; if (sb !== 0)            begin bad++; $display("FAIL mult_sign_held: got %0d changes want 0", sb); end
        total++; if (ns !== 5)            begin bad++; $display("FAIL mult_stall: got %0d want 5", ns); end
        total++; if (Hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", Hi); end
        total++; if (Lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo: got %h want fffffff1", Lo); end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;
    endtask

    task automatic test_divu_mflo();
        int ns, nm, nd, nt, sb; logic s; logic [W-1:0] mf;
        exec_op(F_DIVU, 32'd100, 32'd7, 3, 1, 1'b1, ns, nm, nd, nt, s, sb, mf);
        total++; if (nd !== 1)      begin bad++; $display("FAIL divu_pulses: got %0d want 1", nd); end
        total++; if (s !== 1'b0)    begin bad++; $display("FAIL divu_sign: got %b want 0", s); end
        total++; if (ns !== 4)      begin bad++; $display("FAIL divu_stall: got %0d want 4", ns); end
        total++; if (Hi !== 32'd2)  begin bad++; $display("FAIL divu_hi: got %h want 2", Hi); end
        total++; if (Lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want 14", Lo); end
        m_hi = 32'd2; m_lo = 32'd14;
        exec_op(F_MFLO, $urandom, $urandom, 1, 2, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if (mf !== 32'd14) begin bad++; $display("FAIL mflo_data: got %h want 14", mf); end
        total++; if (ns !== 0)      begin bad++; $display("FAIL mflo_stall: got %0d want 0", ns); end
    endtask

    task automatic test_div_zero();
        int ns, nm, nd, nt, sb; logic s; logic [W-1:0] mf;
        exec_op(F_MTHI, 32'hAA, 32'd0, 1, 2, 1'b0, ns, nm, nd, nt, s, sb, mf);
        m_hi = 32'hAA;
        exec_op(F_DIV, 32'd50, 32'd0, 2, 1, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if (nd !== 0)      begin bad++; $display("FAIL div0_pulses: got %0d want 0", nd); end
        total++; if (ns !== 0)      begin bad++; $display("FAIL div0_stall: got %0d want 0", ns); end
        total++; if (Hi !== 32'hAA) begin bad++; $display("FAIL div0_hi: got %h want aa", Hi); end
        total++; if (Lo !== m_lo)   begin bad++; $display("FAIL div0_lo: got %h want %h", Lo, m_lo); end
    endtask

    task automatic test_mthi_mfhi();
        int ns, nm, nd, nt, sb; logic s; logic [W-1:0] mf;
        exec_op(F_MTHI, 32'h1234, 32'd9, 1, 2, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if (mf !== '0)       begin bad++; $display("FAIL mthi_mf_zero: got %h want 0", mf); end
        total++; if (ns !== 0)        begin bad++; $display("FAIL mthi_stall: got %0d want 0", ns); end
        total++; if (Hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi: got %h want 1234", Hi); end
        m_hi = 32'h1234;
        exec_op(F_MFHI, 32'd0, 32'd0, 1, 2, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if (mf !== 32'h1234) begin bad++; $display("FAIL mfhi_data: got %h want 1234", mf); end
        total++; if (ns !== 0)        begin bad++; $display("FAIL mfhi_stall: got %0d want 0", ns); end
    endtask

    task automatic test_timeout();
        int ns, nm, nd, nt, sb; logic s; logic [W-1:0] mf;
        exec_op(F_MULTU, 32'd6, 32'd7, 1, 2, 1'b0, ns, nm, nd, nt, s, sb, mf);
        // Issue cycle plus TO busy cycles.
        total++; if (ns !== TO + 1) begin bad++; $display("FAIL tmo_stall: got %0d want %0d", ns, TO + 1); end
        total++; if (nt !== 1)      begin bad++; $display("FAIL tmo_pulses: got %0d want 1", nt); end
        total++; if (nm !== 1)      begin bad++; $display("FAIL tmo_starts: got %0d want 1", nm); end
        total++; if (s !== 1'b0)    begin bad++; $display("FAIL tmo_sign: got %b want 0", s); end
        total++; if (Hi !== m_hi)   begin bad++; $display("FAIL tmo_hi: got %h want %h", Hi, m_hi); end
        total++; if (Lo !== m_lo)   begin bad++; $display("FAIL tmo_lo: got %h want %h", Lo, m_lo); end
        @(negedge clk);
        total++; if (stall !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_after: got stall=%b tmo=%b want 0/0", stall, timeout_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        op_valid = 1'b1; funct = F_MULT; SrcA = 32'd3; SrcB = 32'd4;
        @(negedge clk);
        total++; if (mul_validIn !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL flush_issue: got vin=%b stall=%b want 1/1", mul_validIn, stall); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mul_validIn !== 1'b0) begin bad++; $display("FAIL flush_single_pulse: got %b want 0", mul_validIn); end
        @(posedge clk); #1;
        flush = 1'b1; mul_validOut = 1'b1; mul_hi = 32'hDEAD_0001; mul_lo = 32'hDEAD_0002;
        @(posedge clk); #1;
        flush = 1'b0; mul_validOut = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        total++; if (Hi !== m_hi)    begin bad++; $display("FAIL flush_hi: got %h want %h", Hi, m_hi); end
        total++; if (Lo !== m_lo)    begin bad++; $display("FAIL flush_lo: got %h want %h", Lo, m_lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        op_valid = 1'b1; funct = F_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0; div_validOut = 1'b1; div_hi = 32'd1; div_lo = 32'd333;
        @(posedge clk); #1;
        reset_n = 1'b1; div_validOut = 1'b0; op_valid = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", stall); end
        total++; if (Hi !== '0)      begin bad++; $display("FAIL rstmid_hi: got %h want 0", Hi); end
        total++; if (Lo !== '0)      begin bad++; $display("FAIL rstmid_lo: got %h want 0", Lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ns, nm, nd, nt, sb; logic s; logic [W-1:0] mf;
        logic [63:0] r;
        r = ref_res(F_MULTU, 32'h8000_0001, 32'h10);
        exec_op(F_MULTU, 32'h8000_0001, 32'h10, 2, 0, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if ({Hi, Lo} !== r) begin bad++; $display("FAIL b2b_first: got %h want %h", {Hi, Lo}, r); end
        r = ref_res(F_DIV, 32'hFFFF_FF9C, 32'd7);
        exec_op(F_DIV, 32'hFFFF_FF9C, 32'd7, 1, 1, 1'b0, ns, nm, nd, nt, s, sb, mf);
        total++; if (ns !== 2 || nd !== 1) begin bad++; $display("FAIL b2b_second_stall: got %0d/%0d want 2/1", ns, nd); end
        total++; if ({Hi, Lo} !== r) begin bad++; $display("FAIL b2b_second: got %h want %h", {Hi, Lo}, r); end
        m_hi = r[63:32]; m_lo = r[31:0];
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO, F_ADD};
        for (int it = 0; it < 40; it++) begin
            int ns, nm, nd, nt, sb, lat, eu;
            logic s;
            logic [W-1:0] mf, a, b, emf;
            logic [5:0] f;
            logic [63:0] r;
            bit is_mul, is_div;
            f   = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            if (b == 32'hFFFF_FFFF) b = 32'd5;
            lat = $urandom_range(1, 6);
            is_mul = (f == F_MULT) || (f == F_MULTU);
            is_div = ((f == F_DIV) || (f == F_DIVU)) && (b != 0);
            eu  = is_mul ? 0 : (is_div ? 1 : 2);
            emf = (f == F_MFHI) ? m_hi : ((f == F_MFLO) ? m_lo : 32'd0);
            exec_op(f, a, b, lat, eu, (lat >= 2) && $urandom_range(0, 1) == 1,
                    ns, nm, nd, nt, s, sb, mf);
            if (is_mul || is_div) begin
                r = ref_res(f, a, b);
                m_hi = r[63:32]; m_lo = r[31:0];
            end else if (f == F_MTHI) begin
                m_hi = a;
            end else if (f == F_MTLO) begin
                m_lo = a;
            end
            total++; if (ns !== ((is_mul || is_div) ? lat + 1 : 0)) begin bad++; $display("FAIL rnd_stall it=%0d f=%b: got %0d want %0d", it, f, ns, (is_mul || is_div) ? lat + 1 : 0); end
            total++; if (nm !== int'(is_mul) || nd !== int'(is_div)) begin bad++; $display("FAIL rnd_starts it=%0d f=%b: got %0d/%0d want %0d/%0d", it, f, nm, nd, is_mul, is_div); end
            total++; if (mf !== emf)  begin bad++; $display("FAIL rnd_mf it=%0d f=%b: got %h want %h", it, f, mf, emf); end
            total++; if (Hi !== m_hi) begin bad++; $display("FAIL rnd_hi it=%0d f=%b: got %h want %h", it, f, Hi, m_hi); end
            total++; if (Lo !== m_lo) begin bad++; $display("FAIL rnd_lo it=%0d f=%b: got %h want %h", it, f, Lo, m_lo); end
            if (is_mul || is_div) begin
                total++; if (s !== ((f == F_MULT) || (f == F_DIV)) || sb !== 0) begin bad++; $display("FAIL rnd_sign it=%0d f=%b: got %b (changes %0d) want %b", it, f, s, sb, (f == F_MULT) || (f == F_DIV)); end
            end
            total++; if (nt !== 0) begin bad++; $display("FAIL rnd_tmo it=%0d: got %0d want 0", it, nt); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_mflo();
        test_div_zero();
        test_mthi_mfhi();
        test_timeout();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
